// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter: data master wins contention, instr master is served next after a data grant.
// Define WB_ARB_TIMEOUT_EN to add the no-ack timeout (forced ack + timeout_o pulse after TIMEOUT_CYCLES).
module wishbone_arbiter_2m #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc_i,
  input  logic              i_stb_i,
  input  logic              i_we_i,
  input  logic [3:0]        i_sel_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ack_o,
  input  logic              d_cyc_i,
  input  logic              d_stb_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_d_q, last_d_d;
  logic              tmo;
  logic              g_cyc, g_stb, g_we;
  logic [3:0]        g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  // Granted-master mux; everything is zero while idle (grant_q == 00).
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_sel   = '0;
    g_addr  = '0;
    g_wdata = '0;
    if (grant_q[1]) begin
      g_cyc   = d_cyc_i;
      g_stb   = d_stb_i;
      g_we    = d_we_i;
      g_sel   = d_sel_i;
      g_addr  = d_addr_i;
      g_wdata = d_data_i;
    end else if (grant_q[0]) begin
      g_cyc   = i_cyc_i;
      g_stb   = i_stb_i;
      g_we    = i_we_i;
      g_sel   = i_sel_i;
      g_addr  = i_addr_i;
      g_wdata = i_data_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo = g_stb && !s_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (tmo || s_ack_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (g_stb) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Arbitration point: idle, granted master released cyc, or a forced termination.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if ((state_q == IDLE) || !g_cyc || tmo) begin
      if (d_cyc_i && (!i_cyc_i || !last_d_q)) begin
        state_d = GNT_D;
      end else if (i_cyc_i) begin
        state_d = GNT_I;
      end else begin
        state_d = IDLE;
      end
    end
    if ((state_d == GNT_D) && (state_q != GNT_D)) begin
      last_d_d = 1'b1;
    end else if ((state_d == GNT_I) && (state_q != GNT_I)) begin
      last_d_d = 1'b0;
    end
    grant_d = {state_d == GNT_D, state_d == GNT_I};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_d_q <= last_d_d;
    end
  end

  assign s_cyc_o   = g_cyc & ~tmo;
  assign s_stb_o   = g_stb & ~tmo;
  assign s_we_o    = g_we;
  assign s_sel_o   = g_sel;
  assign s_addr_o  = g_addr;
  assign s_data_o  = g_wdata;

  assign i_ack_o   = (s_ack_i | tmo) & grant_q[0];
  assign d_ack_o   = (s_ack_i | tmo) & grant_q[1];
  assign i_data_o  = (grant_q[0] && !tmo) ? s_data_i : '0;
  assign d_data_o  = (grant_q[1] && !tmo) ? s_data_i : '0;

  assign grant_o   = grant_q;
  assign timeout_o = tmo;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed bench for wishbone_arbiter_2m; timeout scenario adapts to WB_ARB_TIMEOUT_EN.
module tb_wishbone_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cyc_i, i_stb_i, i_we_i;
  logic [3:0]  i_sel_i;
  logic [31:0] i_addr_i, i_data_i, i_data_o;
  logic        i_ack_o;
  logic        d_cyc_i, d_stb_i, d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i, d_data_i, d_data_o;
  logic        d_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  wishbone_arbiter_2m #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8),
    .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
    .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_cyc_i = 0; i_stb_i = 0; i_we_i = 0; i_sel_i = '0; i_addr_i = '0; i_data_i = '0;
    d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; d_sel_i = '0; d_addr_i = '0; d_data_i = '0;
    s_ack_i = 0; s_data_i = '0;
    step();
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_init_grant: got %b want 00", grant_o); end
    rst = 1'b1;
    step();
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h0000_0040; d_sel_i = 4'hF;
    step();
    n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL reset_pre_grant: got %b want 10", grant_o); end
    n_chk++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL reset_pre_cyc: got %b want 1", s_cyc_o); end
    s_ack_i = 1; s_data_i = 32'hA5A5_A5A5;
    #1 rst = 1'b0;
    #1;
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_async_grant: got %b want 00", grant_o); end
    n_chk++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL reset_async_cycstb: got %b want 00", {s_cyc_o, s_stb_o}); end
    n_chk++; if ({i_ack_o, d_ack_o} !== 2'b00) begin n_fail++; $display("FAIL reset_async_acks: got %b want 00", {i_ack_o, d_ack_o}); end
    n_chk++; if (s_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_async_addr: got %h want 0", s_addr_o); end
    d_cyc_i = 0; d_stb_i = 0; s_ack_i = 0; s_data_i = '0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_solo_instr();
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'hBFC0_0000; i_sel_i = 4'hF;
    #1;
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL solo_before_edge: got %b want 00", grant_o); end
    step();
    n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL solo_grant: got %b want 01", grant_o); end
    n_chk++; if (s_addr_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL solo_addr: got %h want bfc00000", s_addr_o); end
    n_chk++; if (i_ack_o !== 1'b0) begin n_fail++; $display("FAIL solo_early_ack: got %b want 0", i_ack_o); end
    step();
    step();
    s_ack_i = 1; s_data_i = 32'h3C08_BFC0;
    #1;
    n_chk++; if (i_ack_o !== 1'b1) begin n_fail++; $display("FAIL solo_ack: got %b want 1", i_ack_o); end
    n_chk++; if (i_data_o !== 32'h3C08_BFC0) begin n_fail++; $display("FAIL solo_data: got %h want 3c08bfc0", i_data_o); end
    n_chk++; if ({d_ack_o, d_data_o} !== 33'h0) begin n_fail++; $display("FAIL solo_d_quiet: got %b/%h want 0/0", d_ack_o, d_data_o); end
    step();
    i_cyc_i = 0; i_stb_i = 0; s_ack_i = 0; s_data_i = '0;
    step();
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL solo_release: got %b want 00", grant_o); end
  endtask

  task automatic test_contention();
    i_cyc_i = 1; i_stb_i = 1; i_we_i = 0; i_addr_i = 32'h0000_0100; i_sel_i = 4'hF;
    d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_addr_i = 32'h0000_0200; d_sel_i = 4'h3; d_data_i = 32'h0000_DEAD;
    step();
    n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL cont_first_d: got %b want 10", grant_o); end
    n_chk++; if ({s_we_o, s_sel_o, s_addr_o, s_data_o} !== {1'b1, 4'h3, 32'h0000_0200, 32'h0000_DEAD}) begin
      n_fail++; $display("FAIL cont_mux_d: got we=%b sel=%h addr=%h data=%h want 1/3/00000200/0000dead", s_we_o, s_sel_o, s_addr_o, s_data_o);
    end
    s_ack_i = 1; s_data_i = 32'h1111_1111;
    #1;
    n_chk++; if ({d_ack_o, i_ack_o} !== 2'b10) begin n_fail++; $display("FAIL cont_ack_route: got d=%b i=%b want d=1 i=0", d_ack_o, i_ack_o); end
    n_chk++; if (i_data_o !== 32'h0) begin n_fail++; $display("FAIL cont_i_data_gated: got %h want 0", i_data_o); end
    n_chk++; if (d_data_o !== 32'h1111_1111) begin n_fail++; $display("FAIL cont_d_data: got %h want 11111111", d_data_o); end
    step();
    d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; s_ack_i = 0; s_data_i = '0;
    step();
    n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL cont_handover: got %b want 01", grant_o); end
    n_chk++; if ({s_cyc_o, s_addr_o} !== {1'b1, 32'h0000_0100}) begin n_fail++; $display("FAIL cont_i_on_bus: got cyc=%b addr=%h want 1/00000100", s_cyc_o, s_addr_o); end
    s_ack_i = 1;
    step();
    i_cyc_i = 0; i_stb_i = 0; s_ack_i = 0;
    step();
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL cont_idle: got %b want 00", grant_o); end
  endtask

  // last_d is 0 on entry: both start together, expect D,I,D,I with one-cycle re-requests.
  task automatic test_fairness();
    logic [1:0] exp_g;
    exp_g = 2'b10;
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    step();
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (grant_o !== exp_g) begin n_fail++; $display("FAIL fair_grant_%0d: got %b want %b", k, grant_o, exp_g); end
      s_ack_i = 1;
      step();
      s_ack_i = 0;
      if (exp_g == 2'b10) begin d_cyc_i = 0; d_stb_i = 0; end
      else begin i_cyc_i = 0; i_stb_i = 0; end
      step();
      if (exp_g == 2'b10) begin d_cyc_i = 1; d_stb_i = 1; end
      else begin i_cyc_i = 1; i_stb_i = 1; end
      exp_g = (exp_g == 2'b10) ? 2'b01 : 2'b10;
    end
    i_cyc_i = 0; i_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
    step();
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL fair_idle: got %b want 00", grant_o); end
  endtask

  // Last grant was data: simultaneous requests from idle must go to instr.
  task automatic test_last_d();
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    step();
    n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL lastd_instr_first: got %b want 01", grant_o); end
    i_cyc_i = 0; i_stb_i = 0;
    step();
    n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL lastd_then_d: got %b want 10", grant_o); end
    d_cyc_i = 0; d_stb_i = 0;
    step();
  endtask

  task automatic test_abort();
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h0000_0300;
    step();
    n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL abort_grant_d: got %b want 10", grant_o); end
    i_cyc_i = 1; i_stb_i = 1;
    d_cyc_i = 0; d_stb_i = 0;
    #1;
    n_chk++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL abort_cyc_drop: got %b want 00", {s_cyc_o, s_stb_o}); end
    n_chk++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL abort_grant_held: got %b want 10", grant_o); end
    step();
    n_chk++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL abort_to_instr: got %b want 01", grant_o); end
    i_cyc_i = 0; i_stb_i = 0;
    step();
  endtask

  task automatic test_timeout();
    d_cyc_i = 1; d_stb_i = 1; s_data_i = 32'hFFFF_FFFF;
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      if (c < 8) begin
        n_chk++; if ({d_ack_o, timeout_o, s_cyc_o} !== 3'b001) begin
          n_fail++; $display("FAIL tmo_wait_%0d: got ack=%b tmo=%b cyc=%b want 0/0/1", c, d_ack_o, timeout_o, s_cyc_o);
        end
        step();
      end else begin
        n_chk++; if ({d_ack_o, timeout_o, s_cyc_o, s_stb_o} !== 4'b1100) begin
          n_fail++; $display("FAIL tmo_fire: got ack=%b tmo=%b cyc=%b stb=%b want 1/1/0/0", d_ack_o, timeout_o, s_cyc_o, s_stb_o);
        end
        n_chk++; if (d_data_o !== 32'h0) begin n_fail++; $display("FAIL tmo_data: got %h want 0", d_data_o); end
      end
    end
    step();
    n_chk++; if ({d_ack_o, timeout_o, grant_o} !== 4'b0010) begin
      n_fail++; $display("FAIL tmo_after: got ack=%b tmo=%b grant=%b want 0/0/10", d_ack_o, timeout_o, grant_o);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      n_chk++; if ({d_ack_o, timeout_o, s_cyc_o} !== 3'b001) begin
        n_fail++; $display("FAIL notmo_wait_%0d: got ack=%b tmo=%b cyc=%b want 0/0/1", c, d_ack_o, timeout_o, s_cyc_o);
      end
      step();
    end
`endif
    d_cyc_i = 0; d_stb_i = 0; s_data_i = '0;
    step();
    n_chk++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got %b want 00", grant_o); end
  endtask

  initial begin
    test_reset();
    test_solo_instr();
    test_contention();
    test_fairness();
    test_last_d();
    test_abort();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
